// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host side: address/data widths and the
// port arbiter state encoding.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 24;  // bank(2) + row(13) + col(9)
  localparam int SDRAM_DATA_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Host-side bus between the port arbiter (master) and sdram_controller (slave).
// The controller accepts a command by raising busy. wr_enable/rd_enable stay
// asserted until busy is seen. rd_ready is a one-cycle pulse that qualifies
// rd_data. busy falling marks the end of the command.
interface sdram_port_arbiter_if #(
  parameter int HADDR_WIDTH = sdram_pkg::SDRAM_ADDR_W
);
  logic [HADDR_WIDTH-1:0]            wr_addr;
  logic [HADDR_WIDTH-1:0]            rd_addr;
  logic [sdram_pkg::SDRAM_DATA_W-1:0] wr_data;
  logic [sdram_pkg::SDRAM_DATA_W-1:0] rd_data;
  logic                               wr_enable;
  logic                               rd_enable;
  logic                               rd_ready;
  logic                               busy;

  modport master (
    output wr_addr, rd_addr, wr_data, wr_enable, rd_enable,
    input  rd_data, rd_ready, busy
  );

  modport slave (
    input  wr_addr, rd_addr, wr_data, wr_enable, rd_enable,
    output rd_data, rd_ready, busy
  );
endinterface

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set bit of req at or after
// ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [IW-1:0] idx
);
  logic [IW:0] cand;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!hit && req[cand[IW-1:0]]) begin
        hit = 1'b1;
        idx = cand[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that shares one sdram_controller host port between
// NUM_PORTS clients, one read or write in flight at a time.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int HADDR_WIDTH   = SDRAM_ADDR_W,
  parameter int ISSUE_TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              p_req,
  input  logic [NUM_PORTS-1:0]              p_we,
  input  logic [NUM_PORTS*HADDR_WIDTH-1:0]  p_addr,
  input  logic [NUM_PORTS*SDRAM_DATA_W-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]              p_ack,
  output logic [SDRAM_DATA_W-1:0]           p_rdata,
  sdram_port_arbiter_if.master              ctl,
  output logic                              timeout_err,
  output logic [1:0]                        dbg_state
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(ISSUE_TIMEOUT + 1);

  logic [1:0]              state;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           gnt_idx;
  logic [HADDR_WIDTH-1:0]  cap_addr;
  logic [SDRAM_DATA_W-1:0] cap_wdata;
  logic                    cap_we;
  logic                    rd_seen;
  logic [CW-1:0]           issue_cnt;

  logic [NUM_PORTS-1:0]    req_eff;
  logic                    pick_hit;
  logic [IW-1:0]           pick_idx;
  logic [HADDR_WIDTH-1:0]  sel_addr;
  logic [SDRAM_DATA_W-1:0] sel_wdata;
  logic                    sel_we;

  // The port being acked this cycle may still hold req; it must not win again.
  assign req_eff = p_req & ~p_ack;

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .req (req_eff),
    .ptr (rr_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr  = p_addr[i*HADDR_WIDTH +: HADDR_WIDTH];
        sel_wdata = p_wdata[i*SDRAM_DATA_W +: SDRAM_DATA_W];
        sel_we    = p_we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      cap_we      <= 1'b0;
      rd_seen     <= 1'b0;
      issue_cnt   <= '0;
      p_ack       <= '0;
      p_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      p_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_hit) begin
            gnt_idx   <= pick_idx;
            rr_ptr    <= (pick_idx == IW'(NUM_PORTS-1)) ? '0 : pick_idx + 1'b1;
            cap_addr  <= sel_addr;
            cap_wdata <= sel_wdata;
            cap_we    <= sel_we;
            rd_seen   <= 1'b0;
            issue_cnt <= '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Enables are held through controller init/refresh; only flag a stall.
          if (ctl.busy) begin
            state <= ST_WAIT;
          end else if (issue_cnt != CW'(ISSUE_TIMEOUT)) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == CW'(ISSUE_TIMEOUT - 1)) timeout_err <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (ctl.rd_ready && !cap_we) begin
            p_rdata <= ctl.rd_data;
            rd_seen <= 1'b1;
          end
          if (!ctl.busy) begin
            p_ack[gnt_idx] <= 1'b1;
            if (!cap_we && !rd_seen && !ctl.rd_ready) timeout_err <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ctl.wr_enable = (state == ST_ISSUE) &&  cap_we;
  assign ctl.rd_enable = (state == ST_ISSUE) && !cap_we;
  assign ctl.wr_addr   = cap_addr;
  assign ctl.rd_addr   = cap_addr;
  assign ctl.wr_data   = cap_wdata;
  assign dbg_state     = state;
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one sdram_controller host interface between NUM_PORTS requesters (e.g. video fetch, CPU bridge) using round-robin arbitration.
- Sequences a single read or write at a time: it drives the wr/rd enables, watches controller busy and rd_ready, and returns read data and a completion pulse to the granted port.
- Sits between the clients and sdram_controller in the same clk domain.

Parameters:
- NUM_PORTS, 2, number of requesters (2..4).
- HADDR_WIDTH, 24, host address width (bank+row+col = 2+13+9).
- ISSUE_TIMEOUT, 255, cycles in ISSUE without busy before the sticky error flag sets.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- p_req  in  NUM_PORTS  per-port request level; held high until p_ack.
- p_we  in  NUM_PORTS  per-port 1=write, 0=read; stable while p_req is high.
- p_addr  in  NUM_PORTS*HADDR_WIDTH  flattened per-port address; port i at [i*HADDR_WIDTH +: HADDR_WIDTH].
- p_wdata  in  NUM_PORTS*16  flattened per-port write data.
- p_ack  out  NUM_PORTS  one-cycle completion pulse to the granted port.
- p_rdata  out  16  read data; valid when p_ack is high for a read.
- wr_addr, rd_addr  out  HADDR_WIDTH  to controller; both driven from the captured address.
- wr_data  out  16  to controller.
- wr_enable, rd_enable  out  1  to controller.
- rd_data  in  16  from controller.
- rd_ready  in  1  from controller.
- busy  in  1  from controller.
- timeout_err  out  1  sticky; set on ISSUE timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, gnt_idx=0, wr_enable=rd_enable=0, p_ack=0, p_rdata=0, timeout_err=0, captured addr/data/we=0, issue_cnt=0.
- Arbitration:
  - In IDLE, search for p_req starting at rr_ptr and wrapping modulo NUM_PORTS; the first hit wins.
  - On the edge, capture that port's addr, wdata and we; set gnt_idx; rr_ptr <= gnt_idx+1 (wrapping); go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - Drive wr_enable=we or rd_enable=~we; the other enable stays 0.
  - Hold the enable until busy is sampled 1, then go to WAIT with the enables deasserted on that edge.
  - The controller ignores enables during init and refresh, so holding is correct.
  - issue_cnt counts ISSUE cycles. When it reaches ISSUE_TIMEOUT, timeout_err <= 1; the FSM keeps waiting (no abort).
- WAIT, read:
  - On sampled rd_ready=1: p_rdata <= rd_data and set rd_seen.
  - When busy is sampled 0 with rd_seen set: pulse p_ack[gnt_idx] for one cycle (registered) and go to IDLE.
- WAIT, write: when busy is sampled 0, pulse p_ack[gnt_idx] and go to IDLE.
- rd_ready and busy falling in the same cycle: capture the data and ack on that edge.
- busy dropping in WAIT without rd_ready on a read: ack anyway, p_rdata unchanged, timeout_err <= 1 (protocol error).
- p_ack coincides with the first IDLE cycle. Arbitration in that same cycle ignores the acked port's p_req for that cycle, so a client may drop req on the cycle after ack. Next issue is at earliest one cycle after ack.
- Only one outstanding transaction at any time. Enables are never both high.
- wr_addr and rd_addr are always equal to the captured address. wr_data is always the captured wdata.
- p_req dropping mid-transaction is ignored; the transaction completes and is still acked.
- Reset mid-transaction: everything returns to reset values immediately. The controller must be reset together with the arbiter.

Decomposition:
- Shared package sdram_pkg: arbiter state encoding (IDLE, ISSUE, WAIT), HADDR_WIDTH, and data width 16. The controller uses the same widths.
- One sub-module, rr_pick: combinational round-robin selector taking req vector and rr_ptr, returning hit flag and index. It is reused by later multi-port blocks.

Test Plan:
- Single write: port0 writes addr 24'h012345, data 16'hBEEF after controller init. Expect wr_enable high until busy=1, one p_ack[0] pulse after busy falls, and readback to return BEEF.
- Single read: port1 reads 24'h012345. Expect rd_enable only (wr_enable=0), p_rdata=16'hBEEF with one p_ack[1] pulse, and no second ack.
- Round-robin: both ports request continuously, 4 transactions each. Grant order must be 0,1,0,1,… with no port waiting more than one transaction.
- Refresh collision: issue a request while the controller is in refresh. The enable must stay held, the transaction completes after refresh, timeout_err=0.
- Timeout: hold busy=0 for 300 cycles with port0 requesting. timeout_err rises after 255 ISSUE cycles and stays set.
- Async reset: assert rst_n=0 in WAIT mid-read. All outputs go to 0 immediately. After release, a new write to port0 completes normally with rr_ptr starting at 0.
